// File: rtl/screen_pkg.sv
// ---------------------------------------------------------------------------
// screen_pkg
//   Shared types and constants for the poker display screen sequencer:
//   the screen/FSM state enumeration, the full-brightness fade level, the
//   default keyboard keycodes and the per-channel fade scaling helper.
// ---------------------------------------------------------------------------
package screen_pkg;

    // START and TABLE are the two steady screens. FADE_OUT dims the current
    // screen to black, and FADE_IN brightens the destination screen.
    typedef enum logic [1:0] {
        START    = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2,
        TABLE    = 2'd3
    } screen_t;

    // Fade levels run 0..16, so 16/16 is an exact pass-through.
    localparam logic [4:0] FULL_LEVEL = 5'd16;

    localparam logic [7:0] KEY_ENTER_DEFAULT = 8'h28;
    localparam logic [7:0] KEY_ESC_DEFAULT   = 8'h29;

    // (c * level) >> 4. The widest product is 15 * 16 = 240, which fits in
    // 8 bits, so the shifted result always fits back into a 4-bit channel.
    function automatic logic [3:0] scale_channel(input logic [3:0] c,
                                                 input logic [4:0] level);
        logic [7:0] product;
        product = 8'(c) * 8'(level);
        return 4'(product >> 4);
    endfunction

endpackage

// File: rtl/rgb_fader.sv
// ---------------------------------------------------------------------------
// rgb_fader
//   Purely combinational brightness scaler for one 12-bit RGB pixel.
//   Ports:
//     color_i  [11:0]  input colour {R[3:0], G[3:0], B[3:0]}
//     level_i  [4:0]   brightness 0..16 (0 = black, 16 = unchanged)
//     color_o  [11:0]  scaled colour, same packing as color_i
// ---------------------------------------------------------------------------
module rgb_fader
    import screen_pkg::*;
(
    input  logic [11:0] color_i,
    input  logic [4:0]  level_i,
    output logic [11:0] color_o
);

    assign color_o = {scale_channel(color_i[11:8], level_i),
                      scale_channel(color_i[7:4],  level_i),
                      scale_channel(color_i[3:0],  level_i)};

endmodule

// File: rtl/screen_sequencer.sv
// ---------------------------------------------------------------------------
// screen_sequencer
//   Top-level screen controller for the poker display. It sequences the
//   start screen, a frame-timed fade through black, and the game table
//   screen. Enter starts a game and Esc returns to the start screen. The
//   block picks which renderer's colour reaches the VGA pins, dims that
//   colour during fades, blinks the start text and pulses new_game.
//   Ports:
//     clk                      pixel/system clock
//     reset_n                  asynchronous active-low reset
//     vsync                    VGA vsync (active low), synchronous to clk
//     keycode  [7:0]           current keyboard keycode, 8'h00 = none
//     start_r/g/b [3:0]        start-screen renderer colour
//     table_r/g/b [3:0]        table-screen renderer colour
//     Red/Green/Blue [3:0]     colour driven to the VGA output
//     screen_sel               0 = start renderer selected, 1 = table
//     blink_on                 start-text enable
//     new_game                 one-cycle pulse when the table is first shown
// ---------------------------------------------------------------------------
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int         FADE_STEP_FRAMES = 2,
    parameter int         BLINK_FRAMES     = 30,
    parameter logic [7:0] KEY_ENTER        = KEY_ENTER_DEFAULT,
    parameter logic [7:0] KEY_ESC          = KEY_ESC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic [7:0] keycode,
    input  logic [3:0] start_r,
    input  logic [3:0] start_g,
    input  logic [3:0] start_b,
    input  logic [3:0] table_r,
    input  logic [3:0] table_g,
    input  logic [3:0] table_b,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue,
    output logic       screen_sel,
    output logic       blink_on,
    output logic       new_game
);

    // Counter widths never drop below one bit, so a period of 1 stays legal.
    localparam int STEP_W  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1)     ? $clog2(BLINK_FRAMES)     : 1;

    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // ---------------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------------
    screen_t            state_q;
    screen_t            dest_q;
    logic [4:0]         level_q;
    logic [STEP_W-1:0]  step_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
    logic               new_game_q;
    logic               screen_sel_q;
    logic               vsync_q;
    logic [7:0]         keycode_q;

    // ---------------------------------------------------------------------
    // Edge detectors
    // ---------------------------------------------------------------------
    logic frame_tick;
    logic enter_evt;
    logic esc_evt;
    logic step_last;

    // A frame starts on the falling edge of the active-low vsync.
    assign frame_tick = vsync_q & ~vsync;

    // Keys fire only on the cycle the code first appears. A held key cannot
    // re-fire until the code changes, and presses made during a fade are
    // simply dropped because the registered keycode keeps tracking.
    assign enter_evt  = (keycode == KEY_ENTER) && (keycode_q != KEY_ENTER);
    assign esc_evt    = (keycode == KEY_ESC)   && (keycode_q != KEY_ESC);

    assign step_last  = (step_cnt_q == STEP_LAST);

    // ---------------------------------------------------------------------
    // Sequencer FSM, counters and registered outputs
    // ---------------------------------------------------------------------
    // NOTE: every register in this block uses non-blocking assignment, so
    // each branch sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= START;
            dest_q       <= START;
            level_q      <= FULL_LEVEL;
            step_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            new_game_q   <= 1'b0;
            screen_sel_q <= 1'b0;
            vsync_q      <= 1'b1;
            keycode_q    <= 8'h00;
        end else begin
            vsync_q    <= vsync;
            keycode_q  <= keycode;
            new_game_q <= 1'b0;

            case (state_q)
                START: begin
                    // A key press takes priority over the blink timer.
                    if (enter_evt) begin
                        state_q    <= FADE_OUT;
                        dest_q     <= TABLE;
                        step_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            blink_on_q  <= ~blink_on_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                        end
                    end
                end

                TABLE: begin
                    if (esc_evt) begin
                        state_q    <= FADE_OUT;
                        dest_q     <= START;
                        step_cnt_q <= '0;
                    end
                end

                FADE_OUT: begin
                    if (frame_tick) begin
                        if (step_last) begin
                            step_cnt_q <= '0;
                            level_q    <= level_q - 5'd1;
                            // Reaching black swaps the renderer while the
                            // screen is dark, then the fade reverses.
                            if (level_q == 5'd1) begin
                                state_q      <= FADE_IN;
                                screen_sel_q <= (dest_q == TABLE);
                                new_game_q   <= (dest_q == TABLE);
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                        end
                    end
                end

                FADE_IN: begin
                    if (frame_tick) begin
                        if (step_last) begin
                            step_cnt_q <= '0;
                            level_q    <= level_q + 5'd1;
                            if (level_q == FULL_LEVEL - 5'd1) begin
                                state_q <= dest_q;
                                // The start text always reappears lit, with
                                // a full blink period ahead of it. The table
                                // screen keeps blink_on high.
                                blink_on_q  <= 1'b1;
                                blink_cnt_q <= '0;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= START;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Colour path: combinational, so pixels see no added latency
    // ---------------------------------------------------------------------
    logic [11:0] colour_sel;
    logic [11:0] colour_out;

    assign colour_sel = screen_sel_q ? {table_r, table_g, table_b}
                                     : {start_r, start_g, start_b};

    rgb_fader u_fader (
        .color_i (colour_sel),
        .level_i (level_q),
        .color_o (colour_out)
    );

    assign Red        = colour_out[11:8];
    assign Green      = colour_out[7:4];
    assign Blue       = colour_out[3:0];
    assign screen_sel = screen_sel_q;
    assign blink_on   = blink_on_q;
    assign new_game   = new_game_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_screen_sequencer
//   Self-checking bench for screen_sequencer. A behavioural model tracks the
//   screen as "idle on start", "idle on table" or "fading, t frames in", and
//   derives the brightness, selected screen and blink state arithmetically
//   from t. The model is compared on every cycle. Table-driven colour
//   vectors and hand-written fade sequences cover the documented corners.
// ---------------------------------------------------------------------------
module tb_screen_sequencer;

    localparam int         F       = 2;     // frames per fade step
    localparam int         BL      = 30;    // frames per blink half-period
    localparam int         P       = 8;     // clocks per video frame
    localparam logic [7:0] K_ENT   = 8'h28;
    localparam logic [7:0] K_ESC   = 8'h29;
    localparam logic [7:0] K_OTHER = 8'h04;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vsync;
    logic [7:0] keycode;
    logic [3:0] start_r, start_g, start_b;
    logic [3:0] table_r, table_g, table_b;
    logic [3:0] Red, Green, Blue;
    logic       screen_sel, blink_on, new_game;

    screen_sequencer #(
        .FADE_STEP_FRAMES (F),
        .BLINK_FRAMES     (BL),
        .KEY_ENTER        (K_ENT),
        .KEY_ESC          (K_ESC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .keycode    (keycode),
        .start_r    (start_r),
        .start_g    (start_g),
        .start_b    (start_b),
        .table_r    (table_r),
        .table_g    (table_g),
        .table_b    (table_b),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .screen_sel (screen_sel),
        .blink_on   (blink_on),
        .new_game   (new_game)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ng_count    = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural reference model
    // -----------------------------------------------------------------------
    // mode: 0 = resting on start, 1 = resting on table, 2 = fading.
    typedef struct {
        int         mode;
        bit         dest;         // 1 = fading towards the table
        int         t;            // frame ticks since the fade began
        int         start_ticks;  // frame ticks since the start screen appeared
        bit         ng;
        logic [7:0] kq;
        bit         vq;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t n;
        n.mode = 0; n.dest = 0; n.t = 0; n.start_ticks = 0;
        n.ng = 0; n.kq = 8'h00; n.vq = 1'b1;
        return n;
    endfunction

    function automatic model_t model_step(model_t s, logic [7:0] key, logic vs);
        model_t n;
        bit tick, ent, esc;
        n    = s;
        n.ng = 0;
        tick = s.vq && !vs;
        ent  = (key == K_ENT) && (s.kq != K_ENT);
        esc  = (key == K_ESC) && (s.kq != K_ESC);
        case (s.mode)
            0: begin
                if (ent) begin
                    n.mode = 2; n.dest = 1; n.t = 0;
                end else if (tick) begin
                    n.start_ticks = s.start_ticks + 1;
                end
            end
            1: begin
                if (esc) begin
                    n.mode = 2; n.dest = 0; n.t = 0;
                end
            end
            default: begin
                if (tick) begin
                    n.t = s.t + 1;
                    if (n.t == 16 * F && s.dest) n.ng = 1;
                    if (n.t == 32 * F) begin
                        n.mode        = s.dest ? 1 : 0;
                        n.start_ticks = 0;
                    end
                end
            end
        endcase
        n.kq = key;
        n.vq = vs;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_step(m, keycode, vsync);
    end

    function automatic int exp_level();
        if (m.mode != 2)    return 16;
        if (m.t < 16 * F)   return 16 - m.t / F;
        return (m.t - 16 * F) / F;
    endfunction

    function automatic bit exp_sel();
        if (m.mode == 0) return 1'b0;
        if (m.mode == 1) return 1'b1;
        return (m.t >= 16 * F) ? m.dest : !m.dest;
    endfunction

    function automatic int scale(input logic [3:0] c, input int lvl);
        return (int'(c) * lvl) / 16;
    endfunction

    task automatic model_compare();
        int lvl;
        bit sel;
        lvl = exp_level();
        sel = exp_sel();
        check("model_red",   Red,   scale(sel ? table_r : start_r, lvl));
        check("model_green", Green, scale(sel ? table_g : start_g, lvl));
        check("model_blue",  Blue,  scale(sel ? table_b : start_b, lvl));
        check("model_sel",   screen_sel, sel);
        check("model_new_game", new_game, m.ng);
        if (m.mode == 0)
            check("model_blink_start", blink_on, int'(((m.start_ticks / BL) % 2) == 0));
        else if (m.mode == 1)
            check("model_blink_table", blink_on, 1);
    endtask

    always @(negedge clk) if (new_game === 1'b1) ng_count++;

    // -----------------------------------------------------------------------
    // Cycle helpers: inputs change just after the falling edge; outputs are
    // compared 1 time unit later, well away from the rising edge.
    // -----------------------------------------------------------------------
    task automatic cycle();
        @(negedge clk);
        cyc++;
        vsync = ((cyc % P) >= 2);   // low for two clocks, falling at cyc%P==0
        #1;
        model_compare();
    endtask

    // Advance until n frame ticks have been driven, plus one cycle so their
    // register update is visible.
    task automatic do_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            cycle();
            if (cyc % P == 0) seen++;
        end
        cycle();
    endtask

    // Land mid-frame so a key edge never shares a cycle with a frame tick.
    task automatic sync_mid();
        while (cyc % P != 4) cycle();
    endtask

    task automatic set_colours(input logic [3:0] sr, sg, sb, tr, tg, tb);
        start_r = sr; start_g = sg; start_b = sb;
        table_r = tr; table_g = tg; table_b = tb;
    endtask

    // -----------------------------------------------------------------------
    // Colour pass-through vectors at full brightness
    // -----------------------------------------------------------------------
    typedef struct {
        bit         on_table;
        logic [3:0] sr, sg, sb, tr, tg, tb;
        logic [3:0] er, eg, eb;
    } vec_t;

    vec_t vecs[8];

    task automatic apply_vectors(input bit phase);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].on_table == phase) begin
                set_colours(vecs[i].sr, vecs[i].sg, vecs[i].sb,
                            vecs[i].tr, vecs[i].tg, vecs[i].tb);
                cycle();
                check("vec_red",   Red,   vecs[i].er);
                check("vec_green", Green, vecs[i].eg);
                check("vec_blue",  Blue,  vecs[i].eb);
            end
        end
    endtask

    initial begin
        int ng_before;
        int hold;
        int r;

        vecs[0] = '{0, 4'h0, 4'h1, 4'h2, 4'hF, 4'hE, 4'hD, 4'h0, 4'h1, 4'h2};
        vecs[1] = '{0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
        vecs[2] = '{0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{0, 4'hA, 4'h5, 4'hC, 4'h3, 4'h3, 4'h3, 4'hA, 4'h5, 4'hC};
        vecs[4] = '{1, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'h8, 4'h9, 4'hA};
        vecs[5] = '{1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[7] = '{1, 4'h7, 4'h7, 4'h7, 4'h1, 4'hE, 4'h6, 4'h1, 4'hE, 4'h6};

        // ---- Reset state -------------------------------------------------
        reset_n = 1'b1;
        vsync   = 1'b1;
        keycode = 8'h00;
        set_colours(4'h3, 4'h6, 4'h2, 4'h9, 4'h9, 4'h9);
        #1 reset_n = 1'b0;
        #1;
        check("rst_sel",      screen_sel, 0);
        check("rst_new_game", new_game,   0);
        check("rst_blink",    blink_on,   1);
        check("rst_red",      Red,        4'h3);
        check("rst_green",    Green,      4'h6);
        check("rst_blue",     Blue,       4'h2);
        cycle();
        cycle();
        reset_n = 1'b1;

        // ---- Idle 70 frames on the start screen --------------------------
        do_ticks(29);
        check("blink_29", blink_on, 1);
        do_ticks(1);
        check("blink_30", blink_on, 0);
        do_ticks(30);
        check("blink_60", blink_on, 1);
        do_ticks(10);
        check("idle_sel",   screen_sel, 0);
        check("idle_red",   Red,   4'h3);
        check("idle_green", Green, 4'h6);
        check("idle_blue",  Blue,  4'h2);

        apply_vectors(1'b0);

        // ---- Enter: full fade to the table, key held for 200 frames ------
        set_colours(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        sync_mid();
        ng_before = ng_count;
        keycode   = K_ENT;
        for (int k = 1; k <= 16; k++) begin
            do_ticks(F);
            check("fade_out_red", Red, (15 * (16 - k)) / 16);
            check("fade_out_sel", screen_sel, (k == 16) ? 1 : 0);
            check("fade_out_new_game", new_game, (k == 16) ? 1 : 0);
        end
        cycle();
        check("new_game_drop", new_game, 0);
        for (int k = 1; k <= 16; k++) begin
            do_ticks(F);
            check("fade_in_red", Red, (15 * k) / 16);
            check("fade_in_sel", screen_sel, 1);
        end
        check("table_blink", blink_on, 1);
        do_ticks(200 - 64);
        check("hold_one_new_game", ng_count - ng_before, 1);
        check("hold_sel",   screen_sel, 1);
        check("hold_green", Green, 4'hF);
        keycode = 8'h00;

        apply_vectors(1'b1);

        // ---- Esc: fade back to start, no new_game ------------------------
        set_colours(4'h3, 4'h6, 4'h2, 4'hF, 4'hF, 4'hF);
        sync_mid();
        ng_before = ng_count;
        keycode   = K_ESC;
        do_ticks(32);
        check("esc_black_sel", screen_sel, 0);
        check("esc_black_red", Red, 0);
        do_ticks(32);
        check("esc_start_blink", blink_on, 1);
        check("esc_start_red",   Red,   4'h3);
        check("esc_start_green", Green, 4'h6);
        check("esc_start_blue",  Blue,  4'h2);
        check("esc_no_new_game", ng_count - ng_before, 0);
        keycode = 8'h00;

        // ---- Keys during FADE_OUT are ignored ----------------------------
        set_colours(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        sync_mid();
        keycode = K_ENT;
        do_ticks(4);
        keycode = 8'h00;
        cycle();
        keycode = K_ESC;
        cycle();
        keycode = K_ENT;
        cycle();
        keycode = 8'h00;
        do_ticks(25);                            // 29 ticks: level 2
        check("ignore_red_29", Red, 1);
        do_ticks(2);                             // 31 ticks: level 1
        check("ignore_sel_31", screen_sel, 0);
        do_ticks(1);                             // 32 ticks: black, swap
        check("ignore_sel_32", screen_sel, 1);
        check("ignore_new_game_32", new_game, 1);

        // ---- Reset mid-fade at level 7 -----------------------------------
        do_ticks(14);
        check("mid_fade_red_7", Red, 6);
        start_r = 4'h5; start_g = 4'hA; start_b = 4'hC;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_sel",      screen_sel, 0);
        check("midrst_new_game", new_game,   0);
        check("midrst_blink",    blink_on,   1);
        check("midrst_red",      Red,   4'h5);
        check("midrst_green",    Green, 4'hA);
        check("midrst_blue",     Blue,  4'hC);
        cycle();
        reset_n = 1'b1;

        // ---- Randomised keys and colours against the model ---------------
        hold = 0;
        for (int i = 0; i < 12000; i++) begin
            if (hold <= 0) begin
                r = $urandom_range(0, 19);
                if (r < 12)      keycode = 8'h00;
                else if (r < 14) keycode = K_ENT;
                else if (r < 16) keycode = K_ESC;
                else             keycode = K_OTHER;
                hold = $urandom_range(1, 80);
            end
            hold--;
            set_colours(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
